// File: rtl/ultrasonic_echo_model_pkg.sv
// Shared types and default 50 MHz timing for the ultrasonic echo responder model.
// Pure declarations: no logic, no latency.
package echo_model_pkg;

  typedef enum logic [2:0] {IDLE, TRIG, BURST, ECHO, HOLDOFF} state_t;

  localparam int DEF_DIS_LEN       = 26;
  localparam int DEF_MIN_TRIG_CYC  = 500;      // 10 us
  localparam int DEF_BURST_DLY_CYC = 10000;    // 200 us
  localparam int DEF_TIMEOUT_CYC   = 1900000;  // 38 ms
  localparam int DEF_HOLDOFF_CYC   = 3000000;  // 60 ms

  // Round-trip echo cycles per centimetre of target distance at 50 MHz.
  localparam int CYC_PER_CM = 2900;

  function automatic int unsigned cm_to_cyc(input int unsigned cm);
    return cm * CYC_PER_CM;
  endfunction

endpackage

// File: rtl/ultrasonic_echo_model_if.sv
// Sensor-pin bundle between the supersonic controller (master) and the echo model (slave).
// Wires only: no latency, no flow control.
interface ultrasonic_echo_model_if #(
  parameter int DisLen = echo_model_pkg::DEF_DIS_LEN
);
  logic              enable_i;
  logic              trigger_i;
  logic [DisLen:0]   distance_i;
  logic              object_i;
  logic              echo_o;
  logic              busy_o;
  logic              short_trig_o;
  logic [15:0]       meas_cnt_o;

  modport master (
    output enable_i, trigger_i, distance_i, object_i,
    input  echo_o, busy_o, short_trig_o, meas_cnt_o
  );

  modport slave (
    input  enable_i, trigger_i, distance_i, object_i,
    output echo_o, busy_o, short_trig_o, meas_cnt_o
  );
endinterface

// File: rtl/ultrasonic_echo_model_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency 2 cycles; no backpressure.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/ultrasonic_echo_model.sv
// HC-SR04-style responder: validates the trigger width, then returns an echo of programmed width.
// Echo rises BURST_DLY_CYC+2 cycles after the trigger pin is first sampled low; no backpressure.
module ultrasonic_echo_model
  import echo_model_pkg::*;
#(
  parameter int DisLen        = DEF_DIS_LEN,
  parameter int MIN_TRIG_CYC  = DEF_MIN_TRIG_CYC,
  parameter int BURST_DLY_CYC = DEF_BURST_DLY_CYC,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
  parameter int HOLDOFF_CYC   = DEF_HOLDOFF_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  ultrasonic_echo_model_if.slave  bus
);
  localparam int WCW = $clog2(MIN_TRIG_CYC + 1);

  typedef logic [DisLen:0]  dist_t;
  typedef logic [WCW-1:0]   wcnt_t;

  // The shared down-counter must hold max(TIMEOUT_CYC, HOLDOFF_CYC); DisLen+1 bits covers the defaults.
  localparam dist_t BURST_LD  = dist_t'(BURST_DLY_CYC - 1);
  localparam dist_t HOLD_LD   = dist_t'(HOLDOFF_CYC - 1);
  localparam dist_t TIMEOUT_W = dist_t'(TIMEOUT_CYC);
  localparam dist_t ONE_D     = dist_t'(1);
  localparam wcnt_t MIN_W     = wcnt_t'(MIN_TRIG_CYC);
  localparam wcnt_t ONE_W     = wcnt_t'(1);

  state_t      state_q, state_d;
  dist_t       cnt_q, cnt_d;
  dist_t       wlen_q, wlen_d;
  wcnt_t       wcnt_q, wcnt_d;
  logic [15:0] meas_cnt_q, meas_cnt_d;
  logic        short_d;
  logic        echo_q, busy_q, short_q;
  logic        trig_s, trig_d;
  logic        trig_rise, trig_fall;
  dist_t       dist_clip, w_raw, w_sel;

  bit_sync u_trig_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.trigger_i),
    .q   (trig_s)
  );

  assign trig_rise = trig_s & ~trig_d;
  assign trig_fall = ~trig_s & trig_d;

  // Echo width chosen at the trigger-fall decision; a zero distance still yields a 1-cycle echo.
  assign dist_clip = (bus.distance_i < TIMEOUT_W) ? bus.distance_i : TIMEOUT_W;
  assign w_raw     = bus.object_i ? dist_clip : TIMEOUT_W;
  assign w_sel     = (w_raw == '0) ? ONE_D : w_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    meas_cnt_d = meas_cnt_q;
    short_d    = 1'b0;

    if (!bus.enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trig_rise) begin
            state_d = TRIG;
            wcnt_d  = ONE_W;
          end
        end
        TRIG: begin
          if (trig_fall) begin
            if (wcnt_q >= MIN_W) begin
              state_d = BURST;
              wlen_d  = w_sel;
              cnt_d   = BURST_LD;
            end else begin
              state_d = IDLE;
              short_d = 1'b1;
            end
          end else if (trig_s && (wcnt_q < MIN_W)) begin
            wcnt_d = wcnt_q + ONE_W;
          end
        end
        BURST: begin
          if (cnt_q == '0) begin
            state_d = ECHO;
            cnt_d   = wlen_q - ONE_D;
          end else begin
            cnt_d = cnt_q - ONE_D;
          end
        end
        ECHO: begin
          if (cnt_q == '0) begin
            state_d    = HOLDOFF;
            cnt_d      = HOLD_LD;
            meas_cnt_d = meas_cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q - ONE_D;
          end
        end
        HOLDOFF: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - ONE_D;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      meas_cnt_q <= '0;
      echo_q     <= 1'b0;
      busy_q     <= 1'b0;
      short_q    <= 1'b0;
      trig_d     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wlen_q     <= wlen_d;
      wcnt_q     <= wcnt_d;
      meas_cnt_q <= meas_cnt_d;
      echo_q     <= (state_d == ECHO);
      busy_q     <= (state_d != IDLE);
      short_q    <= short_d;
      trig_d     <= trig_s;
    end
  end

  assign bus.echo_o       = echo_q;
  assign bus.busy_o       = busy_q;
  assign bus.short_trig_o = short_q;
  assign bus.meas_cnt_o   = meas_cnt_q;

endmodule

// File: doc/ultrasonic_echo_model.md
# ultrasonic_echo_model

- Cycle-accurate responder model of the HC-SR04-style ultrasonic sensor: it accepts the `trigger` pulse issued by `supersonic` and returns an `echo` pulse whose width is a programmed number of clock cycles.
- It sits on the sensor pins in place of the physical module, for bench and on-board self-test of the controller/supersonic loop without moving hardware.
- It checks trigger width, models the burst delay, the no-object timeout and the inter-measurement hold-off, and counts completed measurements.

## Interface
Parameters:
- `DisLen`, 26, distance width is `DisLen+1` bits (matches the `supersonic` distance bus)
- `MIN_TRIG_CYC`, 500, minimum accepted trigger high width in cycles (10 µs @ 50 MHz)
- `BURST_DLY_CYC`, 10000, trigger-fall to echo-rise delay in cycles (200 µs)
- `TIMEOUT_CYC`, 1900000, echo width when no object is present; also the cap on any echo width (38 ms)
- `HOLDOFF_CYC`, 3000000, dead time after echo fall during which triggers are ignored (60 ms)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-high reset
- `enable_i` in 1: model active; low forces IDLE
- `trigger_i` in 1: asynchronous trigger from `supersonic`; synchronized internally
- `distance_i` in `DisLen+1`: echo width in cycles when an object is present
- `object_i` in 1: 1 = object present, 0 = produce a timeout echo
- `echo_o` out 1: echo pulse to `supersonic`
- `busy_o` out 1: high in every state except IDLE
- `short_trig_o` out 1: one-cycle pulse when a trigger is rejected as too short
- `meas_cnt_o` out 16: completed echo count; wraps from 0xFFFF to 0

## Operation
- `trigger_i` passes through a 2-FF synchronizer to produce `trig_s`. All edge decisions use `trig_s` and its registered copy.
- IDLE: `echo_o`=0. A `trig_s` rising edge with `enable_i`=1 moves the block to TRIG, with the width counter set to 1.
- TRIG: the width counter increments while `trig_s`=1 and saturates at `MIN_TRIG_CYC`. On the `trig_s` falling edge:
  - If count ≥ `MIN_TRIG_CYC`: latch `W = object_i ? min(distance_i, TIMEOUT_CYC) : TIMEOUT_CYC`, with `W`=0 replaced by 1. Go to BURST.
  - Otherwise: pulse `short_trig_o` and go to IDLE.
- BURST: lasts exactly `BURST_DLY_CYC` cycles, then ECHO.
- ECHO: `echo_o`=1 for exactly `W` cycles, then HOLDOFF. `meas_cnt_o` increments on the ECHO→HOLDOFF transition.
- HOLDOFF: lasts exactly `HOLDOFF_CYC` cycles, then IDLE. Trigger edges during HOLDOFF are ignored. A trigger still high when IDLE is entered is not accepted; a new rising edge is required.
- `distance_i` and `object_i` are sampled only at the TRIG falling-edge decision. Later changes do not affect the echo in progress.
- `enable_i`=0 in any state: go to IDLE on the next edge and clear `echo_o` on that edge. `meas_cnt_o` is unchanged. An aborted echo does not count.
- A `trig_s` rising edge during BURST or ECHO is ignored. A measurement cannot be retriggered.

## Timing
- Reset values: `echo_o`=0, `busy_o`=0, `short_trig_o`=0, `meas_cnt_o`=0, state IDLE, all counters 0. Assertion of `rst` mid-echo drops `echo_o` asynchronously.
- All outputs are registered.
- Synchronizer latency is 2 cycles. With E = the first edge at which `trigger_i` is sampled low after an accepted pulse:
  - `echo_o` rises at edge E+2+`BURST_DLY_CYC` and stays high for `W` cycles.
- Trigger width is measured in `trig_s` cycles, which equals the pin width in cycles. A width of exactly `MIN_TRIG_CYC` is accepted.
- `short_trig_o` is high for the single cycle after the rejecting edge.
- `busy_o` rises the cycle after the trigger is accepted. It falls the cycle after HOLDOFF ends.

## Structure
- `echo_model_pkg` holds:
  - the state enum (IDLE, TRIG, BURST, ECHO, HOLDOFF)
  - default timing constants for a 50 MHz clock
  - the cycles-per-cm constant (2900) for tests that convert centimetres to cycles
- One sub-module: `bit_sync`, a 2-FF synchronizer with asynchronous active-high reset.
- A single shared down-counter, of width `DisLen+1` and sized for the largest of `TIMEOUT_CYC` and `HOLDOFF_CYC`, serves BURST, ECHO and HOLDOFF.

## Test plan
All scenarios use overrides `MIN_TRIG_CYC`=4, `BURST_DLY_CYC`=8, `TIMEOUT_CYC`=100, `HOLDOFF_CYC`=20.
- Trigger high 5 cycles, `distance_i`=37, `object_i`=1 -> `echo_o` rises at E+10, stays high 37 cycles; `meas_cnt_o`=1; `busy_o` low 20 cycles after echo fall.
- Trigger high 3 cycles -> `short_trig_o` high for 1 cycle, no echo, `busy_o` returns to 0, `meas_cnt_o` stays 0.
- `object_i`=0, then separately `distance_i`=500 -> both give echo width 100; `distance_i`=0 -> echo width 1.
- Second trigger during ECHO and during HOLDOFF -> ignored. Trigger held high across HOLDOFF end -> no echo until it falls and rises again.
- `enable_i` dropped mid-ECHO -> `echo_o` 0 next cycle, state IDLE, count unchanged. `rst` asserted mid-BURST -> all outputs reset immediately.
- Preload 65535 measurements via force (or run a loop of them) -> next echo wraps `meas_cnt_o` to 0.
